// File: rtl/sha256_round_ctrl.sv
// SHA-256 single-block compression engine: one round per clock, in-place
// 16-word message schedule, chaining digest held in H0..H7.
module sha256_round_ctrl (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_start,
  input  logic         in_init,
  input  logic [511:0] in_block,
  output logic         out_ready,
  output logic         out_busy,
  output logic         out_done,
  output logic [255:0] out_digest
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned BUF_WORDS  = 16;
  localparam int unsigned HASH_WORDS = 8;
  localparam int unsigned T_W        = 6;
  localparam int unsigned SLOT_W     = 4;

  localparam logic [WORD_W-1:0] K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [WORD_W-1:0] IV [HASH_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t state, state_next;

  logic [T_W-1:0]    t;
  logic [WORD_W-1:0] w_buf [BUF_WORDS];
  logic [WORD_W-1:0] h_reg [HASH_WORDS];
  logic [WORD_W-1:0] wv    [HASH_WORDS];

  logic [SLOT_W-1:0] slot, slot_m2, slot_m7, slot_m15;
  logic              sched_ext;
  logic [WORD_W-1:0] w_t, t1, t2;

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_start) state_next = S_LOAD;
      S_LOAD:  state_next = S_ROUND;
      S_ROUND: if (t == T_W'(NUM_ROUNDS - 1)) state_next = S_FINAL;
      S_FINAL: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Round datapath: schedule word for round t, then T1/T2
  always_comb begin
    slot      = t[SLOT_W-1:0];
    slot_m2   = slot - SLOT_W'(2);
    slot_m7   = slot - SLOT_W'(7);
    slot_m15  = slot - SLOT_W'(15);
    sched_ext = (t[T_W-1:SLOT_W] != '0);
    w_t       = w_buf[slot];
    if (sched_ext) begin
      w_t = small_sigma1(w_buf[slot_m2]) + w_buf[slot_m7]
          + small_sigma0(w_buf[slot_m15]) + w_buf[slot];
    end
    t1 = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[t] + w_t;
    t2 = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
  end

  // Status outputs, registered from the next state
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_ready <= 1'b1;
      out_busy  <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_ready <= (state_next == S_IDLE);
      out_busy  <= (state_next == S_LOAD) || (state_next == S_ROUND) || (state_next == S_FINAL);
      out_done  <= (state_next == S_DONE);
    end
  end

  // Block capture, working registers, schedule buffer and chaining value
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      t <= '0;
      for (int i = 0; i < BUF_WORDS; i++)  w_buf[i] <= '0;
      for (int i = 0; i < HASH_WORDS; i++) begin
        wv[i]    <= '0;
        h_reg[i] <= IV[i];
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            for (int i = 0; i < BUF_WORDS; i++) w_buf[i] <= in_block[511 - 32*i -: 32];
            if (in_init) begin
              for (int i = 0; i < HASH_WORDS; i++) h_reg[i] <= IV[i];
            end
          end
        end
        S_LOAD: begin
          for (int i = 0; i < HASH_WORDS; i++) wv[i] <= h_reg[i];
          t <= '0;
        end
        S_ROUND: begin
          if (sched_ext) w_buf[slot] <= w_t;
          wv[7] <= wv[6];
          wv[6] <= wv[5];
          wv[5] <= wv[4];
          wv[4] <= wv[3] + t1;
          wv[3] <= wv[2];
          wv[2] <= wv[1];
          wv[1] <= wv[0];
          wv[0] <= t1 + t2;
          // Counter parks at the last round instead of wrapping
          if (t != T_W'(NUM_ROUNDS - 1)) t <= t + T_W'(1);
        end
        S_FINAL: begin
          for (int i = 0; i < HASH_WORDS; i++) h_reg[i] <= h_reg[i] + wv[i];
        end
        default: ;
      endcase
    end
  end

  assign out_digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                       h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

endmodule
